// File: rtl/pipelined_lookahead_addsub.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// Each segment resolves SEG result bits per stage and registers its carry for the next segment.
module pipelined_lookahead_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             addSub,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Returns carries c[0..SEG]; every c[i+1] is a flat generate/propagate sum of products.
  function automatic logic [SEG:0] lookahead(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c0);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           acc;
    logic           pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c0);
    end
    return c;
  endfunction

  // Element k of each array is the register at the output of stage k.
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];
  logic             c_q  [STAGES];
  logic             s_q  [STAGES];
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] r_d  [STAGES];
  logic             cm_d [STAGES];
  logic             cm_q;
  logic             zero_q;
  logic             advance;

  assign advance = ~v_q[LAST] | outReady;
  assign inReady = advance & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic             c_in;
    logic             s_in;
    logic             v_in;
    logic [SEG-1:0]   a_seg;
    logic [SEG-1:0]   b_seg;
    logic [SEG-1:0]   seg_sum;
    logic [SEG:0]     cc;

    if (k == 0) begin : g_head
      // Subtract runs as a + ~b + ~borrow_in; the inverted b rides along the skew registers.
      assign a_in = a;
      assign b_in = addSub ? ~b : b;
      assign c_in = cin ^ addSub;
      assign s_in = addSub;
      assign r_in = '0;
      assign v_in = inValid;
    end else begin : g_body
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign c_in = c_q[k-1];
      assign s_in = s_q[k-1];
      assign r_in = r_q[k-1];
      assign v_in = v_q[k-1];
    end

    assign a_seg   = a_in[k*SEG +: SEG];
    assign b_seg   = b_in[k*SEG +: SEG];
    assign cc      = lookahead(a_seg, b_seg, c_in);
    assign seg_sum = a_seg ^ b_seg ^ cc[SEG-1:0];
    assign r_d[k]  = r_in | (WIDTH'(seg_sum) << (k * SEG));
    assign cm_d[k] = cc[SEG-1];

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        s_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else begin
        if (flush) begin
          v_q[k] <= 1'b0;
        end else if (advance) begin
          v_q[k] <= v_in;
        end
        if (advance) begin
          a_q[k] <= a_in;
          b_q[k] <= b_in;
          r_q[k] <= r_d[k];
          c_q[k] <= cc[SEG];
          s_q[k] <= s_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cm_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      cm_q   <= cm_d[LAST];
      zero_q <= ~|r_d[LAST];
    end
  end

  assign outValid = v_q[LAST];
  assign out      = r_q[LAST];
  assign cout     = c_q[LAST] ^ s_q[LAST];
  assign overflow = cm_q ^ c_q[LAST];
  assign zero     = zero_q;

endmodule

// File: tb/tb_pipelined_lookahead_addsub.sv
// Bench for pipelined_lookahead_addsub: directed vectors on an 8-bit/2-stage instance plus a
// random valid/ready sweep over 32-bit instances with 1, 4 and 32 stages.
module tb_pipelined_lookahead_addsub;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, add_sub, flush;
  logic         out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];

  pipelined_lookahead_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk      (clk),
    .rstN     (rst_n),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .addSub   (add_sub),
    .flush    (flush),
    .outValid (out_valid),
    .outReady (out_ready),
    .out      (out),
    .cout     (cout),
    .overflow (ovf),
    .zero     (zero)
  );

  // 32-bit sweep instances share operands but each has its own valid/ready.
  logic        sw_in_valid [3];
  logic        sw_in_ready [3];
  logic        sw_out_valid[3];
  logic        sw_out_ready[3];
  logic [31:0] sw_out      [3];
  logic        sw_cout     [3];
  logic        sw_ovf      [3];
  logic        sw_zero     [3];
  logic [31:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_flush;
  logic [34:0] sw_exp [3][64];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned SS = (g == 0) ? 1 : (g == 1) ? 4 : 32;
    pipelined_lookahead_addsub #(.WIDTH(32), .STAGES(SS)) u_sw (
      .clk      (clk),
      .rstN     (rst_n),
      .inValid  (sw_in_valid[g]),
      .inReady  (sw_in_ready[g]),
      .a        (sw_a),
      .b        (sw_b),
      .cin      (sw_cin),
      .addSub   (sw_sub),
      .flush    (sw_flush),
      .outValid (sw_out_valid[g]),
      .outReady (sw_out_ready[g]),
      .out      (sw_out[g]),
      .cout     (sw_cout[g]),
      .overflow (sw_ovf[g]),
      .zero     (sw_zero[g])
    );
  end

  function automatic int sw_stages(int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 32;
  endfunction

  // Reference: plain integer arithmetic. Returns {zero, overflow, cout, out[31:0]}.
  function automatic logic [34:0] model(int w, logic [31:0] x, logic [31:0] y, logic c,
                                        logic sub);
    longint ux, uy, sx, sy, cc, r, sr, lim;
    logic [31:0] res;
    logic co, ov;
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    cc  = c ? 1 : 0;
    lim = longint'(1) << (w - 1);
    sx  = (ux >= lim) ? ux - 2 * lim : ux;
    sy  = (uy >= lim) ? uy - 2 * lim : uy;
    if (sub) begin
      r  = ux - uy - cc;
      sr = sx - sy - cc;
      co = (r < 0);
    end else begin
      r  = ux + uy + cc;
      sr = sx + sy + cc;
      co = (r >= 2 * lim);
    end
    ov  = (sr >= lim) || (sr < -lim);
    res = 32'(r & (2 * lim - 1));
    return {(res == 32'd0), ov, co, res};
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    add_sub   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    sw_a      = '0;
    sw_b      = '0;
    sw_cin    = 1'b0;
    sw_sub    = 1'b0;
    sw_flush  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw_in_valid[i]  = 1'b0;
      sw_out_ready[i] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out got=%h want=00", out); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b want=0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", ovf); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got=%b want=0", zero); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] ta[5], tb[5], tout[5];
    logic       tc[5], ts[5], tco[5], tov[5], tz[5];
    ta   = '{8'h3C, 8'h10, 8'h80, 8'hFF, 8'h0F};
    tb   = '{8'h55, 8'h20, 8'h01, 8'h01, 8'h00};
    tc   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ts   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tout = '{8'h91, 8'hF0, 8'h7F, 8'h00, 8'h10};
    tco  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tov  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tz   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      a = ta[v]; b = tb[v]; cin = tc[v]; add_sub = ts[v]; in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got=%b want=1", v, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got=%b want=0", v, out_valid); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got=%b want=1", v, out_valid); end
      n_checks++; if (out !== tout[v]) begin n_fail++; $display("FAIL dir%0d_out got=%h want=%h", v, out, tout[v]); end
      n_checks++; if (cout !== tco[v]) begin n_fail++; $display("FAIL dir%0d_cout got=%b want=%b", v, cout, tco[v]); end
      n_checks++; if (ovf !== tov[v]) begin n_fail++; $display("FAIL dir%0d_overflow got=%b want=%b", v, ovf, tov[v]); end
      n_checks++; if (zero !== tz[v]) begin n_fail++; $display("FAIL dir%0d_zero got=%b want=%b", v, zero, tz[v]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    logic        need_new = 1'b1;
    logic        saw_low = 1'b0;
    logic        prev_stalled = 1'b0;
    logic [34:0] prev_obs = '0;
    logic [34:0] obs, e;
    exp_q.delete();
    for (int c = 0; c < 40 && got < 6; c++) begin
      in_valid = (sent < 6);
      if (in_valid && need_new) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); add_sub = 1'($urandom);
      end
      out_ready = !(c >= 3 && c <= 5);
      #1;
      obs = {zero, ovf, cout, 24'd0, out};
      if (prev_stalled) begin
        n_checks++;
        if (obs !== prev_obs) begin n_fail++; $display("FAIL b2b_stall_hold got=%h want=%h", obs, prev_obs); end
      end
      if (c >= 3 && c <= 5 && !in_ready) saw_low = 1'b1;
      need_new = in_valid && in_ready;
      if (need_new) begin
        exp_q.push_back(model(W, {24'd0, a}, {24'd0, b}, cin, add_sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected_out got=%h want=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_fail++; $display("FAIL b2b_result got=%h want=%h", obs, e); end
        end
        got++;
      end
      prev_stalled = out_valid && !out_ready;
      prev_obs     = obs;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (got !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d want=6", got); end
    n_checks++; if (saw_low !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop got=%b want=1", saw_low); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 8'h21 + 8'(i); b = 8'h11; cin = 1'b0; add_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    // Output stalled while flushing: flush must still win.
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 8'h05; b = 8'h06;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid_c%0d got=%b want=0", c, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midstream();
    logic [34:0] e, obs;
    out_ready = 1'b1;
    a = 8'h12; b = 8'h34; cin = 1'b0; add_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h40; b = 8'h02; add_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    n_checks++; if ({out, cout, ovf, zero} !== 11'd0) begin n_fail++; $display("FAIL rstmid_outputs got=%h want=000", {out, cout, ovf, zero}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = 8'hC8; b = 8'h64; cin = 1'b1; add_sub = 1'b0; in_valid = 1'b1;
    e = model(W, {24'd0, a}, {24'd0, b}, cin, add_sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    obs = {zero, ovf, cout, 24'd0, out};
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_latency got=%b want=1", out_valid); end
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL rstmid_result got=%h want=%h", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int          head[3], tail[3], lat[3];
    logic [34:0] e, obs;
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; lat[i] = 0; end
    // Single beat into empty pipes to measure latency.
    sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
    e = model(32, sw_a, sw_b, sw_cin, sw_sub);
    for (int i = 0; i < 3; i++) begin sw_in_valid[i] = 1'b1; sw_out_ready[i] = 1'b1; end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) sw_in_valid[i] = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (sw_out_valid[i] && lat[i] == 0) begin
          lat[i] = cyc;
          obs = {sw_zero[i], sw_ovf[i], sw_cout[i], sw_out[i]};
          n_checks++;
          if (obs !== e) begin n_fail++; $display("FAIL sweep%0d_first got=%h want=%h", i, obs, e); end
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (lat[i] != sw_stages(i)) begin n_fail++; $display("FAIL sweep%0d_latency got=%0d want=%0d", i, lat[i], sw_stages(i)); end
    end
    // Random traffic, then a drain phase with inputs idle.
    for (int cyc = 0; cyc < 11040; cyc++) begin
      sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        sw_in_valid[i]  = (cyc < 11000) && ($urandom_range(0, 9) < 9);
        sw_out_ready[i] = (cyc >= 11000) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sw_in_valid[i] && sw_in_ready[i]) begin
          sw_exp[i][tail[i] % 64] = model(32, sw_a, sw_b, sw_cin, sw_sub);
          tail[i]++;
        end
        if (sw_out_valid[i] && sw_out_ready[i]) begin
          obs = {sw_zero[i], sw_ovf[i], sw_cout[i], sw_out[i]};
          n_checks++;
          if (head[i] == tail[i]) begin
            n_fail++; $display("FAIL sweep%0d_unexpected_out got=%h want=none", i, obs);
          end else begin
            if (obs !== sw_exp[i][head[i] % 64]) begin
              n_fail++;
              $display("FAIL sweep%0d_result beat=%0d got=%h want=%h", i, head[i], obs, sw_exp[i][head[i] % 64]);
            end
            head[i]++;
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (head[i] != tail[i]) begin n_fail++; $display("FAIL sweep%0d_drain got=%0d want=%0d", i, head[i], tail[i]); end
      n_checks++;
      if (tail[i] < 5000) begin n_fail++; $display("FAIL sweep%0d_throughput got=%0d want>=5000", i, tail[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
